// File: rtl/sensor_write_arbiter_pkg.sv
// Shared constants and types for the sensor write arbiter.
// Holds the default record tags, record word counts, datapath and address
// widths, and the arbiter state encoding.
package sensor_write_arbiter_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned GEIG_W = 48;
  localparam int unsigned MAG_W  = 80;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned SR_W   = 128;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DROP_W = 8;

  localparam int unsigned BA_W  = 2;
  localparam int unsigned ROW_W = 13;
  localparam int unsigned COL_W = 9;

  // Record length in words, header included
  localparam int unsigned GEIG_WORDS = 4;
  localparam int unsigned MAG_WORDS  = 6;

  localparam logic [WORD_W-1:0] GEIG_TAG_DEFAULT = 16'hC0A1;
  localparam logic [WORD_W-1:0] MAG_TAG_DEFAULT  = 16'hC0A2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/sdram_addr_counter.sv
// Linear SDRAM write address counter with a sticky wrap flag.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   inc         : advance the address by one word on this edge
//   ba, row, col: current address split into bank / row / column fields
//   wrapped     : set when the address rolls over from all-ones to zero
module sdram_addr_counter
  import sensor_write_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [BA_W-1:0]  ba,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             wrapped
);

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_next;
  logic              wrapped_next;

  // Next address; the register reloads every cycle so its value is always
  // the one computed here
  always_comb begin
    addr_next    = addr;
    wrapped_next = wrapped;
    if (inc) begin
      addr_next = addr + ADDR_W'(1);
      if (addr == {ADDR_W{1'b1}}) begin
        wrapped_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr    <= '0;
      wrapped <= 1'b0;
    end else begin
      addr    <= addr_next;
      wrapped <= wrapped_next;
    end
  end

  assign ba  = addr[ADDR_W-1 -: BA_W];
  assign row = addr[COL_W +: ROW_W];
  assign col = addr[COL_W-1:0];

endmodule

// File: rtl/sensor_write_arbiter.sv
// Merges Geiger and magnetometer samples into tagged multi-word records and
// writes them word by word to an SDRAM write port.
// Ports:
//   CLK_48MHZ, RESET        : clock, synchronous active-high reset
//   ENABLE                  : allows new records to start
//   GEIG_VALID/GEIG_DATA    : Geiger sample strobe and 48-bit payload
//   MAG_VALID/MAG_DATA      : magnetometer sample strobe and 80-bit payload
//   WR_REQ/WR_ACK           : word write handshake
//   DATA_OUT                : word being written
//   BA_OUT/ROW_OUT/COL_OUT  : write address
//   BUSY                    : a record is being transferred
//   WRAPPED                 : sticky address wrap flag
//   GEIG_DROPS/MAG_DROPS    : saturating counts of discarded samples
module sensor_write_arbiter
  import sensor_write_arbiter_pkg::*;
#(
  parameter logic [WORD_W-1:0] GEIG_TAG = GEIG_TAG_DEFAULT,
  parameter logic [WORD_W-1:0] MAG_TAG  = MAG_TAG_DEFAULT
) (
  input  logic              CLK_48MHZ,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              GEIG_VALID,
  input  logic [GEIG_W-1:0] GEIG_DATA,
  input  logic              MAG_VALID,
  input  logic [MAG_W-1:0]  MAG_DATA,
  output logic              WR_REQ,
  input  logic              WR_ACK,
  output logic [WORD_W-1:0] DATA_OUT,
  output logic [BA_W-1:0]   BA_OUT,
  output logic [ROW_W-1:0]  ROW_OUT,
  output logic [COL_W-1:0]  COL_OUT,
  output logic              BUSY,
  output logic              WRAPPED,
  output logic [DROP_W-1:0] GEIG_DROPS,
  output logic [DROP_W-1:0] MAG_DROPS
);

  state_t state;
  state_t state_next;

  logic [GEIG_W-1:0] geig_buf;
  logic [MAG_W-1:0]  mag_buf;
  logic              geig_pend;
  logic              mag_pend;
  logic              prio_mag;
  logic [SR_W-1:0]   sr;
  logic [CNT_W-1:0]  word_cnt;

  logic start_geig;
  logic start_mag;
  logic accept;

  // State register
  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, source selection and word acceptance
  always_comb begin
    state_next = state;
    start_geig = 1'b0;
    start_mag  = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ENABLE && (geig_pend || mag_pend)) begin
          // Geiger wins unless the magnetometer also waits and holds priority
          if (geig_pend && !(mag_pend && prio_mag)) begin
            start_geig = 1'b1;
          end else begin
            start_mag = 1'b1;
          end
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        // WR_REQ is high throughout SEND, so an ack here is a real acceptance
        if (WR_ACK) begin
          accept = 1'b1;
          if (word_cnt == CNT_W'(1)) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sample buffers, drop counters, record shift register and handshake flags
  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      geig_buf   <= '0;
      mag_buf    <= '0;
      geig_pend  <= 1'b0;
      mag_pend   <= 1'b0;
      GEIG_DROPS <= '0;
      MAG_DROPS  <= '0;
      prio_mag   <= 1'b0;
      sr         <= '0;
      word_cnt   <= '0;
      WR_REQ     <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      // A strobe on the start edge refills the buffer being drained
      if (GEIG_VALID) begin
        if (!geig_pend || start_geig) begin
          geig_buf  <= GEIG_DATA;
          geig_pend <= 1'b1;
        end else if (GEIG_DROPS != {DROP_W{1'b1}}) begin
          GEIG_DROPS <= GEIG_DROPS + DROP_W'(1);
        end
      end else if (start_geig) begin
        geig_pend <= 1'b0;
      end

      if (MAG_VALID) begin
        if (!mag_pend || start_mag) begin
          mag_buf  <= MAG_DATA;
          mag_pend <= 1'b1;
        end else if (MAG_DROPS != {DROP_W{1'b1}}) begin
          MAG_DROPS <= MAG_DROPS + DROP_W'(1);
        end
      end else if (start_mag) begin
        mag_pend <= 1'b0;
      end

      // Records sit left-aligned so the top word is always the one on DATA_OUT
      if (start_geig) begin
        sr       <= {GEIG_TAG, geig_buf, {(SR_W-WORD_W-GEIG_W){1'b0}}};
        word_cnt <= CNT_W'(GEIG_WORDS);
        prio_mag <= 1'b1;
      end else if (start_mag) begin
        sr       <= {MAG_TAG, mag_buf, {(SR_W-WORD_W-MAG_W){1'b0}}};
        word_cnt <= CNT_W'(MAG_WORDS);
        prio_mag <= 1'b0;
      end else if (accept) begin
        sr       <= {sr[SR_W-WORD_W-1:0], {WORD_W{1'b0}}};
        word_cnt <= word_cnt - CNT_W'(1);
      end

      WR_REQ <= (state_next == ST_SEND);
      BUSY   <= (state_next == ST_SEND);
    end
  end

  assign DATA_OUT = sr[SR_W-1 -: WORD_W];

  sdram_addr_counter u_addr_counter (
    .clk     (CLK_48MHZ),
    .reset   (RESET),
    .inc     (accept),
    .ba      (BA_OUT),
    .row     (ROW_OUT),
    .col     (COL_OUT),
    .wrapped (WRAPPED)
  );

endmodule

// File: doc/sensor_write_arbiter.md
SENSOR_WRITE_ARBITER -- requirements
Module: sensor_write_arbiter

Interface
REQ-001 The block SHALL have parameter GEIG_TAG, default 16'hC0A1, as the header word prefixed to every Geiger record.
REQ-002 The block SHALL have parameter MAG_TAG, default 16'hC0A2, as the header word prefixed to every magnetometer record.
REQ-003 The block SHALL have port CLK_48MHZ  in  1  sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port ENABLE  in  1  permits starting new records.
REQ-006 The block SHALL have port GEIG_VALID  in  1  one-cycle strobe; GEIG_DATA valid.
REQ-007 The block SHALL have port GEIG_DATA  in  48  Geiger sample.
REQ-008 The block SHALL have port MAG_VALID  in  1  one-cycle strobe; MAG_DATA valid.
REQ-009 The block SHALL have port MAG_DATA  in  80  magnetometer sample.
REQ-010 The block SHALL have port WR_REQ  out  1  word write request to the SDRAM interface.
REQ-011 The block SHALL have port WR_ACK  in  1  SDRAM interface accepted the current word.
REQ-012 The block SHALL have port DATA_OUT  out  16  word to write.
REQ-013 The block SHALL have ports BA_OUT  out  2, ROW_OUT  out  13 and COL_OUT  out  9, together forming the write address.
REQ-014 The block SHALL have port BUSY  out  1  record transfer in progress.
REQ-015 The block SHALL have port WRAPPED  out  1  sticky flag: the address has wrapped.
REQ-016 The block SHALL have ports GEIG_DROPS  out  8 and MAG_DROPS  out  8, saturating lost-sample counters.

Function
REQ-017 Each source SHALL have a one-entry buffer plus a pending flag; a VALID strobe SHALL load the buffer and set pending on that edge.
REQ-018 A VALID strobe arriving while that source is pending SHALL be discarded, leaving the buffer unchanged, and SHALL increment the source's drop counter, saturating at 8'hFF.
REQ-019 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-020 From IDLE, with ENABLE=1 and at least one pending source, the FSM SHALL go to SEND on the next edge.
- On that edge it SHALL load a 128-bit shift register with {tag, payload}.
- It SHALL clear the chosen source's pending flag and set the word count: 4 for Geiger, 6 for magnetometer.
REQ-021 A VALID for the source being started, on the same edge, SHALL be captured as new pending data, not dropped.
REQ-022 When both sources are pending, selection SHALL be round-robin, serving the source not served last; after reset Geiger has priority.
REQ-023 Word order SHALL be the header first, then the payload most-significant 16 bits first.
REQ-024 In SEND, WR_REQ SHALL be 1, with DATA_OUT and the address stable until the edge where WR_REQ and WR_ACK are both 1.
REQ-025 On an accepted word:
- the address SHALL increment by 1;
- the shift register SHALL advance;
- the word count SHALL decrement.
REQ-026 The next word SHALL be presented in the following cycle, with WR_REQ held high.
REQ-027 Acceptance of the last word SHALL return the FSM to IDLE, with WR_REQ=0 in the following cycle.
REQ-028 WR_ACK while WR_REQ=0 SHALL be ignored.
REQ-029 ENABLE=0 SHALL only block new record starts; a record in progress SHALL complete, so records are never split.
REQ-030 The address SHALL be the 24-bit linear value {BA_OUT, ROW_OUT, COL_OUT}.
- Increment SHALL wrap from 24'hFFFFFF to 0.
- The wrap SHALL set WRAPPED, which stays set until reset.
REQ-031 Latency: a VALID sampled at edge k with the FSM idle and ENABLE=1 SHALL give WR_REQ=1 after edge k+1, with DATA_OUT equal to the tag.
REQ-032 BUSY SHALL equal 1 exactly when the state is SEND.

Reset
REQ-033 With RESET=1 at an edge, the block SHALL return to its initial state, overriding every other input:
- state IDLE;
- WR_REQ=0, DATA_OUT=0, address=0, BUSY=0, WRAPPED=0;
- drop counters 0, pending flags 0, round-robin pointer set to Geiger.
REQ-034 A reset in the middle of a record SHALL abandon that record, with no further words issued.

Structure
REQ-035 A shared package SHALL hold:
- the default tags;
- word counts (4, 6) and widths (48, 80, 16, 24);
- the state encoding.
REQ-036 The address counter, including wrap and the WRAPPED flag, SHALL be the sub-module sdram_addr_counter.

Verification
REQ-037 Geiger-only test: GEIG_DATA=48'h111122223333 -> words C0A1, 1111, 2222, 3333 at addresses 0..3, then IDLE.
REQ-038 Simultaneous strobes test: both VALIDs strobe on the same edge -> full Geiger record, then full magnetometer record, address 0..9.
REQ-039 Drop test: a second MAG_VALID arrives while the magnetometer record is pending -> MAG_DROPS=1 and the original data is sent.
REQ-040 Handshake test: WR_ACK held low 5 cycles -> DATA_OUT and the address are held, with no skipped or duplicated word.
REQ-041 Wrap test: the address is preloaded near 24'hFFFFFE and a record is sent -> the address wraps to 0 and WRAPPED=1.
REQ-042 Mid-record reset test: RESET asserted during word 2 -> WR_REQ=0 and all outputs at reset values on the next cycle.
